// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: AND/OR/XOR/NAND on two WIDTH-bit operands,
// carried through STAGES bubble-collapsing register stages, with a saturating result counter.
module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] done_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // valid never depends on ready; in_ready is combinational from out_ready (no skid buffer).

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    logic [WIDTH-1:0]  op_res;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              out_fire;

    always_comb begin
        op_res = '0;
        case (op)
            OP_AND:  op_res = a & b;
            OP_OR:   op_res = a | b;
            OP_XOR:  op_res = a ^ b;
            OP_NAND: op_res = ~(a & b);
            default: op_res = '0;
        endcase
    end

    // A stage may load if it is empty or its contents move on this edge.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !valid_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !valid_q[k] || adv[k+1];
        end
    end

    // Data only loads behind a valid token so bubbles never disturb result.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = op_res;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    assign out_fire = valid_q[STAGES-1] && out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign in_ready   = adv[0];
    assign out_valid  = valid_q[STAGES-1];
    assign result     = data_q[STAGES-1];
    assign zero       = valid_q[STAGES-1] && (data_q[STAGES-1] == '0);
    assign done_count = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: latency/ops on STAGES=2, backpressure and
// throughput on STAGES=3, counter saturation/clear on CNT_W=2, and mid-stream reset.
module tb_logic_unit_pipe;

  logic clk;
  logic rst_n;

  logic       iv2, ir2, ov2, or2, z2, clr2;
  logic [7:0] a2, b2, res2;
  logic [1:0] op2;
  logic [15:0] dc2;

  logic       iv3, ir3, ov3, or3, z3, clr3;
  logic [7:0] a3, b3, res3;
  logic [1:0] op3;
  logic [15:0] dc3;

  logic       ivc, irc, ovc, orc, zc, clrc;
  logic [7:0] ac, bc, resc;
  logic [1:0] opc;
  logic [1:0] dcc;

  int err_cnt;
  int chk_cnt;
  logic [7:0] exp_q[$];

  logic [7:0] ops_exp [5] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h00};
  logic [7:0] bp_a    [6] = '{8'hF0, 8'hF0, 8'hAA, 8'hAA, 8'h12, 8'hFF};
  logic [7:0] bp_b    [6] = '{8'h3C, 8'h3C, 8'h55, 8'h0F, 8'h34, 8'hFF};
  logic [1:0] bp_op   [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
  logic [7:0] bp_exp  [6] = '{8'h30, 8'hFC, 8'hFF, 8'hF5, 8'h36, 8'h00};

  logic_unit_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .op(op2),
    .out_valid(ov2), .out_ready(or2), .result(res2), .zero(z2), .cnt_clr(clr2), .done_count(dc2)
  );

  logic_unit_pipe #(.WIDTH(8), .STAGES(3), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3), .op(op3),
    .out_valid(ov3), .out_ready(or3), .result(res3), .zero(z3), .cnt_clr(clr3), .done_count(dc3)
  );

  logic_unit_pipe #(.WIDTH(8), .STAGES(1), .CNT_W(2)) uc (
    .clk(clk), .rst_n(rst_n), .in_valid(ivc), .in_ready(irc), .a(ac), .b(bc), .op(opc),
    .out_valid(ovc), .out_ready(orc), .result(resc), .zero(zc), .cnt_clr(clrc), .done_count(dcc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  initial begin
    int idx;
    int inflight;
    int popped;
    logic acc;
    logic fire;
    logic [7:0] ra, rb;
    logic [1:0] rop;

    err_cnt = 0;
    chk_cnt = 0;
    rst_n = 1'b0;
    {iv2, a2, b2, op2, clr2} = '0; or2 = 1'b1;
    {iv3, a3, b3, op3, clr3} = '0; or3 = 1'b1;
    {ivc, ac, bc, opc, clrc} = '0; orc = 1'b1;

    #1;
    check("rst_ov2", 32'(ov2), 32'd0);
    check("rst_res2", 32'(res2), 32'd0);
    check("rst_zero2", 32'(z2), 32'd0);
    check("rst_dc2", 32'(dc2), 32'd0);
    check("rst_ov3", 32'(ov3), 32'd0);
    check("rst_dcc", 32'(dcc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ir2", 32'(ir2), 32'd1);
    check("rst_ir3", 32'(ir3), 32'd1);

    // basic latency, STAGES=2
    @(negedge clk);
    iv2 = 1'b1; a2 = 8'hF0; b2 = 8'h3C; op2 = 2'b00;
    @(negedge clk);
    check("lat_ov_c1", 32'(ov2), 32'd0);
    iv2 = 1'b0;
    @(negedge clk);
    check("lat_ov_c2", 32'(ov2), 32'd1);
    check("lat_res", 32'(res2), 32'h30);
    check("lat_zero", 32'(z2), 32'd0);
    @(negedge clk);
    check("lat_ov_c3", 32'(ov2), 32'd0);
    check("lat_dc", 32'(dc2), 32'd1);

    // all ops back to back, then a zero result
    for (int i = 0; i < 7; i++) begin
      if (i >= 2) begin
        check("ops_ov", 32'(ov2), 32'd1);
        check("ops_res", 32'(res2), 32'(ops_exp[i-2]));
        check("ops_zero", 32'(z2), 32'(i == 6));
      end
      if (i < 4) begin
        iv2 = 1'b1; a2 = 8'hF0; b2 = 8'h3C; op2 = 2'(i);
      end else if (i == 4) begin
        iv2 = 1'b1; a2 = 8'h0F; b2 = 8'hF0; op2 = 2'b00;
      end else begin
        iv2 = 1'b0; a2 = 8'h5A; b2 = 8'hA5; op2 = 2'b11;
      end
      #1;
      check("ops_ir", 32'(ir2), 32'd1);
      @(negedge clk);
    end
    check("ops_ov_end", 32'(ov2), 32'd0);
    check("ops_dc", 32'(dc2), 32'd6);

    // backpressure, STAGES=3
    idx = 0; inflight = 0; popped = 0;
    for (int c = 0; c < 40 && popped < 6; c++) begin
      @(negedge clk);
      or3 = !(c >= 2 && c < 7);
      if (idx < 6) begin
        iv3 = 1'b1; a3 = bp_a[idx]; b3 = bp_b[idx]; op3 = bp_op[idx];
      end else begin
        iv3 = 1'b0;
      end
      #1;
      check("bp_ir", 32'(ir3), 32'(inflight < 3 || or3));
      if (ov3) begin
        if (exp_q.size() > 0) check("bp_res", 32'(res3), 32'(exp_q[0]));
        else check("bp_spurious", 32'(ov3), 32'd0);
      end
      fire = ov3 && or3;
      acc  = iv3 && ir3;
      if (fire && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        popped++;
        inflight--;
      end
      if (acc) begin
        exp_q.push_back(bp_exp[idx]);
        idx++;
        inflight++;
      end
    end
    check("bp_popped", 32'(popped), 32'd6);
    @(negedge clk);
    iv3 = 1'b0;
    check("bp_ov_end", 32'(ov3), 32'd0);
    check("bp_dc", 32'(dc3), 32'd6);
    exp_q.delete();

    // full throughput, STAGES=3
    or3 = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c < 10) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rop = 2'($urandom_range(0, 3));
        iv3 = 1'b1; a3 = ra; b3 = rb; op3 = rop;
        exp_q.push_back(ref_op(ra, rb, rop));
      end else begin
        iv3 = 1'b0;
      end
      #1;
      check("ft_ov", 32'(ov3), 32'(c >= 3 && c <= 12));
      if (ov3 && exp_q.size() > 0) check("ft_res", 32'(res3), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
    check("ft_dc", 32'(dc3), 32'd16);

    // counter saturation and clear, CNT_W=2, STAGES=1
    for (int c = 0; c < 8; c++) begin
      if (c >= 2 && c <= 6) check("cnt_sat", 32'(dcc), 32'((c - 1 > 3) ? 3 : c - 1));
      if (c == 7) check("cnt_clr", 32'(dcc), 32'd0);
      if (c >= 1 && c <= 6) begin
        check("cnt_ov", 32'(ovc), 32'd1);
        check("cnt_res", 32'(resc), 32'(c - 1));
      end
      ivc = (c < 6); ac = 8'hFF; bc = 8'(c); opc = 2'b00;
      clrc = (c == 6);
      @(negedge clk);
    end
    clrc = 1'b0;

    // reset with two items in flight
    or2 = 1'b0;
    iv2 = 1'b1; a2 = 8'hF0; b2 = 8'h3C; op2 = 2'b01;
    @(negedge clk);
    a2 = 8'h0F; op2 = 2'b10;
    @(negedge clk);
    iv2 = 1'b0;
    check("pre_rst_ov", 32'(ov2), 32'd1);
    check("pre_rst_ir", 32'(ir2), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 32'(ov2), 32'd0);
    check("mid_rst_res", 32'(res2), 32'd0);
    check("mid_rst_dc", 32'(dc2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    or2 = 1'b1;
    #1;
    check("post_rst_ir", 32'(ir2), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_ov", 32'(ov2), 32'd0);
    end
    check("post_rst_dc", 32'(dc2), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's single-bit combinational AND example.
- Applies a selectable bitwise operation (AND/OR/XOR/NAND) to two WIDTH-bit operands and carries the result through STAGES register stages.
- Valid/ready handshakes on both input and output; accepts one operation per cycle when not back-pressured.
- Keeps a saturating count of completed results. Used as a bench-friendly datapath building block ahead of the ALU.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
STAGES, 2, pipeline depth in register stages (>=1); also the unstalled latency in cycles
CNT_W, 16, width of completed-result counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept bundle this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
zero  output  1  result == 0, qualified by out_valid
cnt_clr  input  1  synchronous clear of done_count
done_count  output  CNT_W  number of out handshakes, saturating

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0, stage data 0, done_count 0.
  - Hence out_valid=0, result=0, zero=0, and in_ready=1 (after reset releases, since stages are empty).
- Input accept: in_valid && in_ready.
  - The result is computed combinationally from a, b, op and written into stage 0 at that edge.
  - Stages 1..STAGES-1 pass data unchanged.
- Stage advance (bubble-collapsing):
  - Last stage: adv[S-1] = !valid[S-1] || out_ready.
  - Other stages: adv[k] = !valid[k] || adv[k+1].
  - Stage k loads from stage k-1 (stage 0 loads from input) when adv[k].
  - valid[k] takes valid[k-1] (stage 0: in_valid) on load; otherwise it holds.
- in_ready = adv[0]. This is a combinational path from out_ready; no skid buffer.
- Output: out_valid = valid[S-1], result = data[S-1], zero = out_valid && (data[S-1]==0).
- Latency: with out_ready held 1, a bundle accepted at edge N gives out_valid high after edge N+STAGES-1, i.e. the result is visible in cycle N+STAGES relative to the cycle of the input handshake. With STAGES=1, the result appears the cycle after accept.
- Throughput: 1 bundle/cycle when out_ready=1. Internal bubbles are collapsed; a stalled output still lets upstream stages fill.
- Backpressure:
  - While out_valid && !out_ready, result and zero hold stable.
  - Once all STAGES are valid, in_ready=0.
  - No data is dropped or duplicated.
- Simultaneous accept and output handshake when full: allowed; the pipeline shifts and in_ready=1 that cycle.
- in_valid deasserted: bubbles enter the pipeline; a, b, op are don't-care.
- done_count:
  - Increments on out_valid && out_ready and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 forces 0 at the next edge and takes priority over a same-cycle increment.
- Reset mid-operation: in-flight results are discarded, with no spurious out_valid afterward.
- op/a/b values with in_valid=0 never affect outputs.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 items in flight -> out_valid=0, result=0, done_count=0 immediately (no clock); after release in_ready=1 and no stale result appears.
- Basic latency, STAGES=2, WIDTH=8, out_ready=1: a=8'hF0, b=8'h3C, op=AND accepted at cycle 0 -> out_valid=1, result=8'h30, zero=0 in cycle 2 only; done_count=1.
- All ops, same a/b, back-to-back for 4 cycles -> results 30, FC, CC, CF in consecutive cycles. Then a=8'h0F, b=8'hF0, op=AND -> result=00, zero=1.
- Backpressure, STAGES=3: stream 6 items and hold out_ready=0 from cycle 2 for 5 cycles -> in_ready=0 once 3 items are held; result stable throughout; after release all 6 results arrive in order with no loss or duplication.
- Full throughput, STAGES=3: 10 random items with in_valid=1 and out_ready=1 -> 10 results on 10 consecutive cycles starting cycle 3, matching a reference model; done_count=10.
- Counter, CNT_W=2: 5 handshakes -> done_count 1, 2, 3, 3, 3. Then cnt_clr=1 coinciding with a handshake -> done_count=0.
